// File: rtl/divu_seq_16bit.sv
// Purpose : sequential unsigned restoring divider, one quotient bit per cycle.
// Latency : WIDTH+1 cycles from accepted start to done (1 cycle for divide by zero).
// Backpres: start is ignored while busy; results are held until the next done.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 request, sampled only when busy=0
//   dividend, divisor     operands, sampled with an accepted start
//   busy                  high while an accepted division iterates
//   done                  single-cycle pulse, results valid that cycle
//   quotient, remainder   registered results, held between operations
//   div_by_zero           set with done when the divisor was 0
module divu_seq_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_q, q_d;
  // The partial remainder is always below the divisor between iterations, so
  // its top (WIDTH+1th) bit is always 0 once stored; that bit only exists
  // transiently in the shifted/trial values below.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign shifted = {rem_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_q};
  assign borrow  = trial[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      q_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      remo_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    q_d       = q_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            divisor_d = divisor;
            q_d       = dividend;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
            state_d   = RUN;
          end else begin
            // Divide by zero resolves immediately without iterating.
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Publish the values produced by this final iteration.
          quot_d  = q_d;
          remo_d  = rem_d;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq_16bit.sv
// Purpose : self-checking bench for divu_seq_16bit against an arithmetic model.
// Latency : expects done 17 cycles after an accepted start, 1 for divide by zero.
// Backpres: exercises ignored starts while busy and back-to-back starts.
module tb_divu_seq_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int errors;

  divu_seq_16bit #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z, output int lat);
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = 17;
    end
  endfunction

  // Issue one start (called just after a rising edge with the DUT idle or in
  // its done cycle) and wait, bounded, for done. lat=-1 on timeout.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic z, output int lat, output int nbusy);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = -1; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL reset_quot got %h want 0", quotient); end
    checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL reset_rem got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic;
    logic [15:0] q, r; logic z; int lat, nb;
    run_div(16'd100, 16'd7, q, r, z, lat, nb);
    checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
    checks++; if (nb !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", nb); end
    checks++; if (q !== 16'd14) begin errors++; $display("FAIL basic_quot got %0d want 14", q); end
    checks++; if (r !== 16'd2) begin errors++; $display("FAIL basic_rem got %0d want 2", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", z); end
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got %b want 0", done); end
    step(4);
    checks++; if (quotient !== 16'd14 || remainder !== 16'd2)
      begin errors++; $display("FAIL basic_hold got %0d r%0d want 14 r2", quotient, remainder); end
  endtask

  task automatic test_boundary;
    logic [15:0] ta [4] = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd0};
    logic [15:0] tb [4] = '{16'h0001, 16'hFFFF, 16'd9, 16'd3};
    logic [15:0] q, r, eq, er; logic z, ez; int lat, el, nb;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], eq, er, ez, el);
      run_div(ta[i], tb[i], q, r, z, lat, nb);
      checks++; if (q !== eq || r !== er || z !== ez || lat !== el)
        begin errors++; $display("FAIL boundary_%0d got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                                 i, q, r, z, lat, eq, er, ez, el); end
      step(1);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b, q, r, eq, er; logic z, ez; int lat, el, nb;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      model(a, b, eq, er, ez, el);
      run_div(a, b, q, r, z, lat, nb);
      checks++; if (q !== eq || r !== er || z !== ez || lat !== el)
        begin errors++; $display("FAIL random_%0d %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                                 i, a, b, q, r, z, lat, eq, er, ez, el); end
      if (i % 2 == 0) step(1);
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] q, r; logic z; int lat, nb;
    run_div(16'h1234, 16'h0000, q, r, z, lat, nb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (nb !== 0 || busy !== 1'b0) begin errors++; $display("FAIL dz_busy got %0d want 0", nb); end
    checks++; if (q !== 16'hFFFF || r !== 16'h1234 || z !== 1'b1)
      begin errors++; $display("FAIL dz_result got q=%h r=%h z=%b want ffff 1234 1", q, r, z); end
    run_div(16'd9, 16'd3, q, r, z, lat, nb);
    checks++; if (q !== 16'd3 || r !== 16'd0 || z !== 1'b0 || lat !== 17)
      begin errors++; $display("FAIL dz_followup got q=%0d r=%0d z=%b lat=%0d want 3 0 0 17", q, r, z, lat); end
    step(1);
  endtask

  task automatic test_ignore_start;
    int lat;
    start = 1'b1; dividend = 16'd60000; divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin start = 1'b1; dividend = 16'd5; divisor = 16'd1; end
      if (c == 6) start = 1'b0;
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got %0d want 17", lat); end
    checks++; if (quotient !== 16'd8571 || remainder !== 16'd3)
      begin errors++; $display("FAIL ignore_result got %0d r%0d want 8571 r3", quotient, remainder); end
    step(1);
  endtask

  task automatic test_reset_mid;
    logic [15:0] q, r; logic z; int lat, nb, ndone;
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got q=%h r=%h z=%b want 0 0 0", quotient, remainder, div_by_zero); end
    step(2);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", ndone); end
    run_div(16'd1000, 16'd10, q, r, z, lat, nb);
    checks++; if (q !== 16'd100 || r !== 16'd0 || lat !== 17 || nb !== 16)
      begin errors++; $display("FAIL midrst_rerun got q=%0d r=%0d lat=%0d busy=%0d want 100 0 17 16", q, r, lat, nb); end
    step(1);
  endtask

  task automatic test_back_to_back;
    int ndone;
    int dcyc [2];
    logic [15:0] rq [2];
    logic [15:0] rr [2];
    logic held;
    ndone = 0; held = 1'b1;
    dcyc[0] = -1; dcyc[1] = -1;
    rq[0] = '0; rq[1] = '0; rr[0] = '0; rr[1] = '0;
    start = 1'b1; dividend = 16'd200; divisor = 16'd9;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ndone == 1 && !done && quotient !== 16'd22) held = 1'b0;
      if (done) begin
        dcyc[ndone] = c; rq[ndone] = quotient; rr[ndone] = remainder;
        ndone++;
        if (ndone == 1) begin dividend = 16'd50; divisor = 16'd7; end
        else begin start = 1'b0; break; end
      end
    end
    checks++; if (dcyc[0] !== 17 || dcyc[1] !== 34)
      begin errors++; $display("FAIL b2b_timing got %0d,%0d want 17,34", dcyc[0], dcyc[1]); end
    checks++; if (rq[0] !== 16'd22 || rr[0] !== 16'd2)
      begin errors++; $display("FAIL b2b_first got %0d r%0d want 22 r2", rq[0], rr[0]); end
    checks++; if (rq[1] !== 16'd7 || rr[1] !== 16'd1)
      begin errors++; $display("FAIL b2b_second got %0d r%0d want 7 r1", rq[1], rr[1]); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got %b want 1", held); end
    step(2);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
